// File: rtl/galvo_scan_sequencer.sv
// Galvo scan sequencer.
// Steps the position PID through a table of target points. Each point is
// read from a small synchronous RAM, issued to the PID with a one-cycle
// strobe, and then held until the ADC reports it within tolerance for enough
// consecutive samples. The point is then held for a dwell time before the
// scan advances, either as a single pass or in a loop.
//
// Handshake semantics: there is no back-pressure anywhere in this block.
// start, abort, pt_wr_en and pos_adc_data_valid are single-cycle strobes that
// are sampled on the rising edge of clk_pid. new_target_valid and done are
// single-cycle strobes produced here; new_target_valid is high in exactly the
// cycle in which pos_target first shows the new value.
module galvo_scan_sequencer #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_pid,
  input  logic              sys_rstn,
  input  logic              pt_wr_en,
  input  logic [ADDR_W-1:0] pt_wr_addr,
  input  logic [15:0]       pt_wr_data,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       settle_tol,
  input  logic [3:0]        settle_cnt,
  input  logic [CNT_W-1:0]  dwell_cycles,
  input  logic [CNT_W-1:0]  timeout_cycles,
  input  logic              pos_adc_data_valid,
  input  logic [15:0]       pos_adc,
  output logic [15:0]       pos_target,
  output logic              new_target_valid,
  output logic [ADDR_W-1:0] cur_idx,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [2:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DWELL  = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;

  localparam logic [15:0] POS_CENTRE = 16'd32768;

  logic [15:0]       r_mem [0:DEPTH-1];
  logic [15:0]       r_rd_data;

  logic [2:0]        r_state;
  logic              r_load_wait;
  logic [15:0]       r_pos_target;
  logic              r_new_target_valid;
  logic [ADDR_W-1:0] r_cur_idx;
  logic              r_done;
  logic              r_timeout_err;
  logic [3:0]        r_in_tol_cnt;
  logic [CNT_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0]  r_dwell_cnt;

  logic              w_rd_en;
  logic signed [16:0] w_diff;
  logic [16:0]       w_abs_diff;
  logic              w_in_tol;
  logic [4:0]        w_need;
  logic [4:0]        w_tol_next;
  logic              w_settled;
  logic [CNT_W-1:0]  w_to_next;
  logic              w_timeout;

  // The table is read once, in the first LOAD cycle; the second LOAD cycle
  // just lets the registered read data settle before ISSUE uses it.
  assign w_rd_en = (r_state == S_LOAD) && !r_load_wait;

  // Distance from target in 17-bit signed arithmetic so no value can wrap.
  assign w_diff     = $signed({1'b0, pos_adc}) - $signed({1'b0, r_pos_target});
  assign w_abs_diff = w_diff[16] ? 17'(-w_diff) : 17'(w_diff);
  assign w_in_tol   = (w_abs_diff <= {1'b0, settle_tol});

  // A settle count of zero behaves as one.
  assign w_need     = (settle_cnt == 4'd0) ? 5'd1 : {1'b0, settle_cnt};
  assign w_tol_next = {1'b0, r_in_tol_cnt} + 5'd1;
  assign w_settled  = pos_adc_data_valid && w_in_tol && (w_tol_next >= w_need);

  assign w_to_next  = r_to_cnt + CNT_W'(1);
  assign w_timeout  = (timeout_cycles != '0) && (w_to_next >= timeout_cycles);

  // Point table: write port always open, registered read returns old data on
  // a same-address collision.
  always_ff @(posedge clk_pid) begin
    if (pt_wr_en) begin
      r_mem[pt_wr_addr] <= pt_wr_data;
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[r_cur_idx];
    end
  end

  // Scan sequencing FSM with its counters and output registers.
  always_ff @(posedge clk_pid or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state            <= S_IDLE;
      r_load_wait        <= 1'b0;
      r_pos_target       <= POS_CENTRE;
      r_new_target_valid <= 1'b0;
      r_cur_idx          <= '0;
      r_done             <= 1'b0;
      r_timeout_err      <= 1'b0;
      r_in_tol_cnt       <= '0;
      r_to_cnt           <= '0;
      r_dwell_cnt        <= '0;
    end else begin
      r_new_target_valid <= 1'b0;
      r_done             <= 1'b0;
      if (abort) begin
        r_state     <= S_IDLE;
        r_load_wait <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_cur_idx     <= '0;
              r_timeout_err <= 1'b0;
              r_load_wait   <= 1'b0;
              r_state       <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (r_load_wait) begin
              r_load_wait <= 1'b0;
              r_state     <= S_ISSUE;
            end else begin
              r_load_wait <= 1'b1;
            end
          end
          S_ISSUE: begin
            r_pos_target       <= r_rd_data;
            r_new_target_valid <= 1'b1;
            r_in_tol_cnt       <= '0;
            r_to_cnt           <= '0;
            r_state            <= S_SETTLE;
          end
          S_SETTLE: begin
            r_to_cnt <= w_to_next;
            if (pos_adc_data_valid) begin
              if (w_in_tol) begin
                r_in_tol_cnt <= w_tol_next[4] ? 4'hF : w_tol_next[3:0];
              end else begin
                r_in_tol_cnt <= '0;
              end
            end
            // Settling takes precedence over a timeout in the same cycle.
            if (w_settled) begin
              r_dwell_cnt <= dwell_cycles;
              r_state     <= S_DWELL;
            end else if (w_timeout) begin
              r_timeout_err <= 1'b1;
              r_state       <= S_IDLE;
            end
          end
          S_DWELL: begin
            if (r_dwell_cnt == '0) begin
              r_state <= S_NEXT;
            end else begin
              r_dwell_cnt <= r_dwell_cnt - CNT_W'(1);
            end
          end
          S_NEXT: begin
            if (r_cur_idx != last_idx) begin
              r_cur_idx <= r_cur_idx + ADDR_W'(1);
              r_state   <= S_LOAD;
            end else if (loop_en) begin
              r_cur_idx <= '0;
              r_state   <= S_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign pos_target       = r_pos_target;
  assign new_target_valid = r_new_target_valid;
  assign cur_idx          = r_cur_idx;
  assign busy             = (r_state != S_IDLE);
  assign done             = r_done;
  assign timeout_err      = r_timeout_err;
  assign dbg_state        = r_state;

endmodule

// File: doc/galvo_scan_sequencer.md
Name: galvo_scan_sequencer

Overview:
Sequences the position PID loop through a programmed list of galvo target points. It drives pos_target and a new-target strobe into the position PID, then watches ADC position samples until the mirror settles within tolerance. It dwells for a programmable time, then advances to the next point, either once or looping. It sits between the SPI register/config logic and the position PID on the clk_pid domain.

Parameters:
ADDR_W, 4, point-table address width (table depth = 2^ADDR_W entries)
CNT_W, 16, width of the dwell and timeout counters

Ports:
clk_pid  in  1  PID-domain clock; all logic is rising-edge
sys_rstn  in  1  reset, asynchronous assert, active-low
pt_wr_en  in  1  write strobe into the point table
pt_wr_addr  in  ADDR_W  point-table write address
pt_wr_data  in  16  target position (unsigned offset binary, 32768 = centre)
last_idx  in  ADDR_W  index of the final point in the scan
loop_en  in  1  1 = wrap from last_idx to index 0; 0 = single pass
start  in  1  one-cycle pulse that begins a scan at index 0
abort  in  1  one-cycle pulse that stops the scan
settle_tol  in  16  maximum |pos_adc - pos_target| counted as settled
settle_cnt  in  4  consecutive in-tolerance samples required; 0 is treated as 1
dwell_cycles  in  CNT_W  clk_pid cycles to hold a point after it settles
timeout_cycles  in  CNT_W  maximum cycles from ISSUE to settled; 0 disables the timeout
pos_adc_data_valid  in  1  one-cycle strobe marking a new ADC sample
pos_adc  in  16  position ADC sample, same encoding as the targets
pos_target  out  16  target driven to the PID
new_target_valid  out  1  one-cycle strobe, asserted the same cycle pos_target changes
cur_idx  out  ADDR_W  index of the point currently being served
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a single-pass scan completes
timeout_err  out  1  sticky flag; cleared by the next accepted start

Behaviour:
- Reset values: pos_target = 32768; new_target_valid = 0; cur_idx = 0; busy = 0; done = 0; timeout_err = 0; state = IDLE; all counters = 0. Point-table contents are not reset.
- Point table:
  - 2^ADDR_W x 16 synchronous RAM with a registered read.
  - Writes are accepted in any state.
  - On a same-cycle read and write to the same address, the read returns the old data.
- IDLE:
  - start = 1 and abort = 0 -> cur_idx = 0, clear timeout_err, go to LOAD.
- LOAD:
  - Read address = cur_idx; wait one cycle, then go to ISSUE.
- ISSUE:
  - pos_target <= RAM data; new_target_valid = 1 for exactly one cycle.
  - Clear the settle and timeout counters; go to SETTLE.
  - Latency: pos_target and new_target_valid update on the 3rd rising edge after the edge that samples start.
- SETTLE:
  - On each pos_adc_data_valid, compute d = |{1'b0,pos_adc} - {1'b0,pos_target}| in 17-bit signed arithmetic.
  - d <= settle_tol -> increment the in-tolerance count; otherwise reset it to 0.
  - When the count reaches max(settle_cnt,1) -> load the dwell counter with dwell_cycles and go to DWELL.
  - The timeout counter increments every cycle. If timeout_cycles != 0 and the counter reaches timeout_cycles before settling -> timeout_err = 1 and go to IDLE. pos_target is held and done stays 0.
  - Settling and timeout in the same cycle: settling wins.
- DWELL:
  - Decrement the dwell counter each cycle; at 0 go to NEXT. dwell_cycles = 0 spends exactly one cycle in DWELL.
- NEXT:
  - cur_idx != last_idx -> cur_idx + 1, go to LOAD.
  - cur_idx == last_idx and loop_en = 1 -> cur_idx = 0, go to LOAD.
  - cur_idx == last_idx and loop_en = 0 -> done = 1 for one cycle, go to IDLE.
  - loop_en and last_idx are sampled at NEXT and may change mid-scan.
- abort:
  - In any state -> IDLE next cycle; pos_target is held and done stays 0.
  - abort has priority over start in the same cycle.
- start while busy is ignored.
- Asynchronous reset mid-scan: all outputs return to their reset values immediately, including pos_target = 32768.

Test Plan:
- Load points [40000, 30000, 32768]; last_idx = 2, loop_en = 0, settle_tol = 64, settle_cnt = 3, dwell_cycles = 10; model the ADC tracking the target with error 20 -> three new_target_valid strobes with targets 40000, 30000, 32768 in order; done pulses once; busy falls the same cycle done pulses.
- Settle filter: one target, settle_cnt = 3; ADC errors 10, 10, 100, 10, 10, 10 -> DWELL is entered only after the 6th sample.
- Timeout: timeout_cycles = 500, ADC stuck at 0 with target 40000 -> timeout_err = 1 at cycle 500 after ISSUE; busy = 0; done never pulses; the next start clears timeout_err.
- Loop: last_idx = 1, loop_en = 1 -> cur_idx sequence 0,1,0,1,...; abort mid-DWELL -> IDLE next cycle; pos_target is held.
- Same cycle start + abort in IDLE -> stays IDLE. start while busy -> ignored; the scan sequence is unchanged.
- Table write to address 1 while serving index 1 -> current pos_target is unchanged; the new value is issued on the next pass. Reset asserted mid-SETTLE -> pos_target = 32768 and busy = 0 immediately.
